// File: rtl/regfile_pkg.sv
// Shared types and sizes for the register-file writeback path.
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Destinations past the implemented registers are discarded rather than queued.
    function automatic logic is_writable(input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} < (ADDR_W + 1)'(NUM_REGS);
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Two-write / one-read circular buffer; exposes every entry in age order
// (index 0 = oldest) with a matching valid mask so the top can bypass from it.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push0,
    input  wb_entry_t             entry0,
    input  logic                  push1,
    input  wb_entry_t             entry1,
    input  logic                  pop,
    output wb_entry_t [DEPTH-1:0] age_entry,
    output logic      [DEPTH-1:0] age_valid,
    output logic      [CNT_W-1:0] count
);

    wb_entry_t        entry_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next, wr_ptr_inc;
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;

    // push1 is only ever asserted together with push0, so it lands one slot later.
    assign wr_ptr_inc  = wr_ptr_reg + PTR_W'(1);
    assign wr_ptr_next = wr_ptr_reg + PTR_W'(push0) + PTR_W'(push1);
    assign rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
    assign count_next  = count_reg + CNT_W'(push0) + CNT_W'(push1) - CNT_W'(pop);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge clock) begin
        if (push0) entry_mem[wr_ptr_reg] <= entry0;
        if (push1) entry_mem[wr_ptr_inc] <= entry1;
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_age
            logic [PTR_W-1:0] idx;
            assign idx           = rd_ptr_reg + PTR_W'(gi);
            assign age_entry[gi] = entry_mem[idx];
            assign age_valid[gi] = CNT_W'(gi) < count_reg;
        end
    endgenerate

    assign count = count_reg;

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: arbitrates mem/ALU writebacks into a small queue,
// drains one per cycle to the register file and bypasses queued values to rs/rt.
module regfile_wb_ctrl
    import regfile_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_dest,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_dest,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              rf_hold,
    output logic              rf_wr,
    output logic [ADDR_W-1:0] rf_controle,
    output logic [DATA_W-1:0] rf_entrada,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic              fwdA_hit,
    output logic [DATA_W-1:0] fwdA_data,
    output logic              fwdB_hit,
    output logic [DATA_W-1:0] fwdB_data,
    output logic [CNT_W-1:0]  count,
    output logic              drop_err
);

    localparam int FREE_W = CNT_W + 1;

    wb_entry_t [DEPTH-1:0] age_entry;
    logic      [DEPTH-1:0] age_valid;
    logic      [FREE_W-1:0] free;
    logic                  pop;
    logic                  mem_acc, alu_acc, mem_keep, alu_keep;
    logic                  push0, push1;
    wb_entry_t             entry0, entry1;
    logic                  drop_err_reg, drop_err_next;

    assign pop   = (count != '0) & ~rf_hold;
    assign rf_wr = pop;

    // A slot freed by this cycle's pop is immediately reusable.
    assign free      = FREE_W'(DEPTH) - FREE_W'(count) + FREE_W'(pop);
    assign mem_ready = free != '0;
    assign alu_ready = (free >= FREE_W'(2)) | ((free == FREE_W'(1)) & ~mem_valid);

    assign mem_acc  = mem_valid & mem_ready;
    assign alu_acc  = alu_valid & alu_ready;
    assign mem_keep = mem_acc & is_writable(mem_dest);
    assign alu_keep = alu_acc & is_writable(alu_dest);

    // Memory goes in first (older); a lone surviving ALU request takes slot 0.
    assign push0  = mem_keep | alu_keep;
    assign push1  = mem_keep & alu_keep;
    assign entry0 = mem_keep ? wb_entry_t'{dest: mem_dest, data: mem_data}
                             : wb_entry_t'{dest: alu_dest, data: alu_data};
    assign entry1 = wb_entry_t'{dest: alu_dest, data: alu_data};

    assign drop_err_next = drop_err_reg | (mem_acc & ~mem_keep) | (alu_acc & ~alu_keep);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) drop_err_reg <= 1'b0;
        else        drop_err_reg <= drop_err_next;
    end
    assign drop_err = drop_err_reg;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push0     (push0),
        .entry0    (entry0),
        .push1     (push1),
        .entry1    (entry1),
        .pop       (pop),
        .age_entry (age_entry),
        .age_valid (age_valid),
        .count     (count)
    );

    assign rf_controle = age_entry[0].dest;
    assign rf_entrada  = age_entry[0].data;

    // Scan oldest to youngest so the last match (youngest) wins.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic [ADDR_W-1:0] addr;
            logic              hit;
            logic [DATA_W-1:0] data;
            assign addr = (gi == 0) ? rs : rt;
            always_comb begin
                hit  = 1'b0;
                data = '0;
                for (int k = 0; k < DEPTH; k++) begin
                    if (age_valid[k] && is_writable(addr) && age_entry[k].dest == addr) begin
                        hit  = 1'b1;
                        data = age_entry[k].data;
                    end
                end
            end
        end
    endgenerate

    assign fwdA_hit  = g_fwd[0].hit;
    assign fwdA_data = g_fwd[0].data;
    assign fwdB_hit  = g_fwd[1].hit;
    assign fwdB_data = g_fwd[1].data;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed vector table plus reset and randomized scoreboard sequences for regfile_wb_ctrl.
module tb_regfile_wb_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_valid, alu_valid, rf_hold;
    logic        mem_ready, alu_ready, rf_wr;
    logic [4:0]  mem_dest, alu_dest, rs, rt, rf_controle;
    logic [31:0] mem_data, alu_data, rf_entrada, fwdA_data, fwdB_data;
    logic        fwdA_hit, fwdB_hit, drop_err;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    regfile_wb_ctrl #(.DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_dest(mem_dest), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
        .rf_hold(rf_hold), .rf_wr(rf_wr), .rf_controle(rf_controle), .rf_entrada(rf_entrada),
        .rs(rs), .rt(rt),
        .fwdA_hit(fwdA_hit), .fwdA_data(fwdA_data), .fwdB_hit(fwdB_hit), .fwdB_data(fwdB_data),
        .count(count), .drop_err(drop_err)
    );

    typedef struct {
        logic        hold, mv, av;
        logic [4:0]  md, ad, ra, rb;
        logic [31:0] mdat, adat;
        logic        e_mr, e_ar, e_wr, e_ah, e_bh, e_drop;
        logic [4:0]  e_ctl;
        logic [31:0] e_ent, e_ad, e_bd;
        logic [2:0]  e_cnt;
    } vec_t;

    typedef struct {
        logic [4:0]  d;
        logic [31:0] v;
    } ment_t;

    vec_t        vtab[$];
    ment_t       q[$];
    logic [31:0] model_regs [16];
    logic [31:0] bench_rf   [16];
    logic        model_drop;

    function automatic vec_t mk(input int hold, input int mv, input int md, input int mdat,
                                input int av, input int ad, input int adat, input int ra, input int rb,
                                input int e_mr, input int e_ar, input int e_wr, input int e_ctl,
                                input int e_ent, input int e_ah, input int e_ad, input int e_bh,
                                input int e_bd, input int e_cnt, input int e_drop);
        vec_t v;
        v.hold = 1'(hold); v.mv = 1'(mv); v.md = 5'(md); v.mdat = 32'(mdat);
        v.av = 1'(av); v.ad = 5'(ad); v.adat = 32'(adat); v.ra = 5'(ra); v.rb = 5'(rb);
        v.e_mr = 1'(e_mr); v.e_ar = 1'(e_ar); v.e_wr = 1'(e_wr); v.e_ctl = 5'(e_ctl);
        v.e_ent = 32'(e_ent); v.e_ah = 1'(e_ah); v.e_ad = 32'(e_ad); v.e_bh = 1'(e_bh);
        v.e_bd = 32'(e_bd); v.e_cnt = 3'(e_cnt); v.e_drop = 1'(e_drop);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_valid = 0; mem_dest = 0; mem_data = 0;
        alu_valid = 0; alu_dest = 0; alu_data = 0;
        rf_hold = 0; rs = 0; rt = 0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    function automatic void lookup(input logic [4:0] a, output logic hit, output logic [31:0] d);
        hit = 0;
        d   = 0;
        if (a < 16) begin
            foreach (q[k]) begin
                if (q[k].d == a) begin
                    hit = 1;
                    d   = q[k].v;
                end
            end
        end
    endfunction

    initial begin
        vec_t        v;
        logic        e_pop, e_mr, e_ar, eh;
        logic [31:0] ed;
        int          free_slots, bound;

        idle_inputs();
        reset = 0;
        #2;
        chk("reset count", 32'(count), 0);
        chk("reset rf_wr", 32'(rf_wr), 0);
        chk("reset drop_err", 32'(drop_err), 0);
        next_cycle();
        next_cycle();
        reset = 1;

        // Directed table: single write, held dual pushes, full+pop, drops.
        vtab.push_back(mk(0, 0,0,0,           0,0,0,           0,0,   1,1, 0,0,0,            0,0,            0,0,    0,0));
        vtab.push_back(mk(0, 0,0,0,           1,3,'hDEADBEEF,  0,0,   1,1, 0,0,0,            0,0,            0,0,    0,0));
        vtab.push_back(mk(0, 0,0,0,           0,0,0,           3,0,   1,1, 1,3,'hDEADBEEF,   1,'hDEADBEEF,   0,0,    1,0));
        vtab.push_back(mk(0, 0,0,0,           0,0,0,           3,0,   1,1, 0,0,0,            0,0,            0,0,    0,0));
        vtab.push_back(mk(1, 1,5,'h11,        1,5,'h22,        0,0,   1,1, 0,0,0,            0,0,            0,0,    0,0));
        vtab.push_back(mk(1, 1,6,'h33,        1,7,'h44,        5,6,   1,1, 0,0,0,            1,'h22,         0,0,    2,0));
        vtab.push_back(mk(1, 0,0,0,           0,0,0,           5,7,   0,0, 0,0,0,            1,'h22,         1,'h44, 4,0));
        vtab.push_back(mk(0, 1,8,'h55,        1,9,'h66,        5,6,   1,0, 1,5,'h11,         1,'h22,         1,'h33, 4,0));
        vtab.push_back(mk(0, 0,0,0,           0,0,0,           8,9,   1,1, 1,5,'h22,         1,'h55,         0,0,    4,0));
        vtab.push_back(mk(0, 0,0,0,           0,0,0,           5,7,   1,1, 1,6,'h33,         0,0,            1,'h44, 3,0));
        vtab.push_back(mk(0, 0,0,0,           0,0,0,           0,0,   1,1, 1,7,'h44,         0,0,            0,0,    2,0));
        vtab.push_back(mk(0, 0,0,0,           0,0,0,           0,0,   1,1, 1,8,'h55,         0,0,            0,0,    1,0));
        vtab.push_back(mk(0, 0,0,0,           0,0,0,           0,0,   1,1, 0,0,0,            0,0,            0,0,    0,0));
        vtab.push_back(mk(0, 0,0,0,           1,20,'h77,       20,0,  1,1, 0,0,0,            0,0,            0,0,    0,0));
        vtab.push_back(mk(0, 0,0,0,           0,0,0,           20,20, 1,1, 0,0,0,            0,0,            0,0,    0,1));
        vtab.push_back(mk(0, 1,31,'h99,       1,2,'hAB,        2,0,   1,1, 0,0,0,            0,0,            0,0,    0,1));
        vtab.push_back(mk(0, 0,0,0,           0,0,0,           2,31,  1,1, 1,2,'hAB,         1,'hAB,         0,0,    1,1));
        vtab.push_back(mk(0, 0,0,0,           0,0,0,           0,0,   1,1, 0,0,0,            0,0,            0,0,    0,1));

        foreach (vtab[i]) begin
            v = vtab[i];
            rf_hold = v.hold;
            mem_valid = v.mv; mem_dest = v.md; mem_data = v.mdat;
            alu_valid = v.av; alu_dest = v.ad; alu_data = v.adat;
            rs = v.ra; rt = v.rb;
            #3;
            $display("vec %0d: cnt=%0d wr=%0d ctl=%0d ent=%h fwdA=%0d/%h fwdB=%0d/%h",
                     i, count, rf_wr, rf_controle, rf_entrada, fwdA_hit, fwdA_data, fwdB_hit, fwdB_data);
            chk($sformatf("v%0d mem_ready", i), 32'(mem_ready), 32'(v.e_mr));
            chk($sformatf("v%0d alu_ready", i), 32'(alu_ready), 32'(v.e_ar));
            chk($sformatf("v%0d rf_wr", i),     32'(rf_wr),     32'(v.e_wr));
            if (v.e_wr) begin
                chk($sformatf("v%0d rf_controle", i), 32'(rf_controle), 32'(v.e_ctl));
                chk($sformatf("v%0d rf_entrada", i),  rf_entrada,       v.e_ent);
            end
            chk($sformatf("v%0d fwdA_hit", i),  32'(fwdA_hit), 32'(v.e_ah));
            chk($sformatf("v%0d fwdA_data", i), fwdA_data,     v.e_ad);
            chk($sformatf("v%0d fwdB_hit", i),  32'(fwdB_hit), 32'(v.e_bh));
            chk($sformatf("v%0d fwdB_data", i), fwdB_data,     v.e_bd);
            chk($sformatf("v%0d count", i),     32'(count),    32'(v.e_cnt));
            chk($sformatf("v%0d drop_err", i),  32'(drop_err), 32'(v.e_drop));
            next_cycle();
        end

        // Reset asserted while the queue is draining.
        idle_inputs();
        rf_hold = 1;
        mem_valid = 1; mem_dest = 1; mem_data = 32'hA1;
        alu_valid = 1; alu_dest = 2; alu_data = 32'hA2;
        next_cycle();
        idle_inputs();
        rs = 2;
        #3;
        chk("rst pre rf_wr", 32'(rf_wr), 1);
        chk("rst pre count", 32'(count), 2);
        next_cycle();
        #1;
        chk("rst mid rf_wr", 32'(rf_wr), 1);
        chk("rst mid controle", 32'(rf_controle), 2);
        reset = 0;
        #1;
        $display("reset mid-drain: wr=%0d cnt=%0d drop=%0d hitA=%0d", rf_wr, count, drop_err, fwdA_hit);
        chk("rst async rf_wr", 32'(rf_wr), 0);
        chk("rst async count", 32'(count), 0);
        chk("rst async drop_err", 32'(drop_err), 0);
        chk("rst async fwdA_hit", 32'(fwdA_hit), 0);
        next_cycle();
        reset = 1;
        next_cycle();
        #2;
        chk("rst after rf_wr", 32'(rf_wr), 0);
        chk("rst after count", 32'(count), 0);

        // Randomized traffic against a queue model and a register-file scoreboard.
        for (int r = 0; r < 16; r++) begin
            model_regs[r] = 0;
            bench_rf[r]   = 0;
        end
        model_drop = 0;
        q.delete();
        for (int c = 0; c < 300; c++) begin
            rf_hold   = ($urandom_range(0, 9) < 3);
            mem_valid = ($urandom_range(0, 9) < 6);
            alu_valid = ($urandom_range(0, 9) < 6);
            mem_dest  = ($urandom_range(0, 15) == 0) ? 5'(16 + $urandom_range(0, 15)) : 5'($urandom_range(0, 7));
            alu_dest  = ($urandom_range(0, 15) == 0) ? 5'(16 + $urandom_range(0, 15)) : 5'($urandom_range(0, 7));
            mem_data  = $urandom;
            alu_data  = $urandom;
            rs        = ($urandom_range(0, 9) == 0) ? 5'd20 : 5'($urandom_range(0, 9));
            rt        = 5'($urandom_range(0, 9));
            #3;
            e_pop      = (q.size() != 0) && !rf_hold;
            free_slots = 4 - q.size() + (e_pop ? 1 : 0);
            e_mr       = (free_slots >= 1);
            e_ar       = (free_slots >= 2) || (free_slots == 1 && !mem_valid);
            chk($sformatf("r%0d mem_ready", c), 32'(mem_ready), 32'(e_mr));
            chk($sformatf("r%0d alu_ready", c), 32'(alu_ready), 32'(e_ar));
            chk($sformatf("r%0d rf_wr", c),     32'(rf_wr),     32'(e_pop));
            chk($sformatf("r%0d count", c),     32'(count),     32'(q.size()));
            if (e_pop) begin
                chk($sformatf("r%0d rf_controle", c), 32'(rf_controle), 32'(q[0].d));
                chk($sformatf("r%0d rf_entrada", c),  rf_entrada,       q[0].v);
            end
            lookup(rs, eh, ed);
            chk($sformatf("r%0d fwdA_hit", c),  32'(fwdA_hit), 32'(eh));
            chk($sformatf("r%0d fwdA_data", c), fwdA_data,     ed);
            lookup(rt, eh, ed);
            chk($sformatf("r%0d fwdB_hit", c),  32'(fwdB_hit), 32'(eh));
            chk($sformatf("r%0d fwdB_data", c), fwdB_data,     ed);
            $display("rnd %0d: hold=%0d mem=%0d/%0d alu=%0d/%0d wr=%0d ctl=%0d cnt=%0d",
                     c, rf_hold, mem_valid, mem_dest, alu_valid, alu_dest, rf_wr, rf_controle, count);
            if (rf_wr && rf_controle < 16) bench_rf[rf_controle[3:0]] = rf_entrada;
            if (e_pop) void'(q.pop_front());
            if (mem_valid && e_mr) begin
                if (mem_dest < 16) begin
                    q.push_back('{d: mem_dest, v: mem_data});
                    model_regs[mem_dest[3:0]] = mem_data;
                end else model_drop = 1;
            end
            if (alu_valid && e_ar) begin
                if (alu_dest < 16) begin
                    q.push_back('{d: alu_dest, v: alu_data});
                    model_regs[alu_dest[3:0]] = alu_data;
                end else model_drop = 1;
            end
            next_cycle();
        end

        idle_inputs();
        bound = 0;
        #3;
        while (count != 0 && bound < 20) begin
            if (rf_wr && rf_controle < 16) bench_rf[rf_controle[3:0]] = rf_entrada;
            next_cycle();
            #2;
            bound++;
        end
        chk("drain count", 32'(count), 0);
        chk("drain drop_err", 32'(drop_err), 32'(model_drop));
        for (int r = 0; r < 16; r++)
            chk($sformatf("final reg%0d", r), bench_rf[r], model_regs[r]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
